// File: rtl/lenet_pkg.sv
// Shared LeNet constants and the flattener FSM state encoding.
package lenet_pkg;

  localparam int LENET_DATA_WIDTH = 12;
  localparam int POOL2_CH         = 16;
  localparam int POOL2_MAP        = 25;
  localparam int FC1_IN           = 400;
  localparam int FC1_OUT          = 120;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } flat_state_e;

endpackage

// File: rtl/fc_flatten_buf.sv
// One-frame buffer: MAP_SIZE rows of NUM_CH channel words.
// A full row is written per cycle; one element is read per cycle through a
// registered read port.
module fc_flatten_buf #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CH     = 16,
  parameter int MAP_SIZE   = 25
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [$clog2(MAP_SIZE)-1:0]    wr_pos,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   wr_row,
  input  logic                           rd_en,
  input  logic [$clog2(MAP_SIZE)-1:0]    rd_pos,
  input  logic [$clog2(NUM_CH)-1:0]      rd_ch,
  output logic [DATA_WIDTH-1:0]          rd_data
);

  localparam int ROW_W = NUM_CH * DATA_WIDTH;

  logic [ROW_W-1:0]      mem_q [MAP_SIZE];
  logic [ROW_W-1:0]      mem_d [MAP_SIZE];
  logic [ROW_W-1:0]      rd_row;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Row write: the addressed position takes the whole incoming beat.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_pos] = wr_row;
    end
  end

  // Element select; a same-cycle write to the read row is forwarded so the
  // register never captures a stale row.
  always_comb begin
    rd_row    = (wr_en && (wr_pos == rd_pos)) ? wr_row : mem_q[rd_pos];
    rd_data_d = rd_en ? rd_row[rd_ch*DATA_WIDTH +: DATA_WIDTH] : rd_data_q;
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Registered read data, cleared by reset so the output starts at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fc_input_flattener.sv
// Buffers one pool2 frame (position-major beats) and streams it to FC1 as
// FC_IN scalars in channel-major order: index = c*MAP_SIZE + p.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FILL  | accepting pool2 beats into buffer rows 0..MAP_SIZE-1
//   ST_DRAIN | streaming buffer out one scalar per accept; input blocked
module fc_input_flattener
  import lenet_pkg::*;
#(
  parameter  int DATA_WIDTH = LENET_DATA_WIDTH,
  parameter  int NUM_CH     = POOL2_CH,
  parameter  int MAP_SIZE   = POOL2_MAP,
  localparam int FC_IN      = NUM_CH * MAP_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FC_IN)-1:0]      out_idx,
  output logic                          out_last,
  output logic                          frame_done
);

  localparam int POS_W = $clog2(MAP_SIZE);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int IDX_W = $clog2(FC_IN);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(MAP_SIZE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FC_IN - 1);

  flat_state_e      state_q, state_d;
  logic [POS_W-1:0] wr_pos_q, wr_pos_d;
  logic [POS_W-1:0] rd_pos_q, rd_pos_d;
  logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_done_q, frame_done_d;

  logic in_fire;
  logic out_fire;
  logic fill_last;
  logic rd_en;

  // Next-state, counter and handshake logic.
  always_comb begin
    state_d      = state_q;
    wr_pos_d     = wr_pos_q;
    rd_pos_d     = rd_pos_q;
    rd_ch_d      = rd_ch_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;

    in_ready  = (state_q == ST_FILL);
    out_valid = (state_q == ST_DRAIN);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    fill_last = in_fire && (wr_pos_q == POS_LAST);

    unique case (state_q)
      ST_FILL: begin
        if (in_fire) begin
          if (fill_last) begin
            wr_pos_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            wr_pos_d = wr_pos_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          idx_d = idx_q + 1'b1;
          if (rd_pos_q == POS_LAST) begin
            rd_pos_d = '0;
            if (rd_ch_q == CH_LAST) begin
              rd_ch_d      = '0;
              idx_d        = '0;
              state_d      = ST_FILL;
              frame_done_d = 1'b1;
            end else begin
              rd_ch_d = rd_ch_q + 1'b1;
            end
          end else begin
            rd_pos_d = rd_pos_q + 1'b1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase

    // The read register is addressed with the next read position, so the
    // element for the first drain cycle is fetched on the last fill accept.
    rd_en = (state_q == ST_DRAIN) || fill_last;
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      wr_pos_q     <= '0;
      rd_pos_q     <= '0;
      rd_ch_q      <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_pos_q     <= wr_pos_d;
      rd_pos_q     <= rd_pos_d;
      rd_ch_q      <= rd_ch_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  fc_flatten_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH),
    .MAP_SIZE   (MAP_SIZE)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_fire),
    .wr_pos  (wr_pos_q),
    .wr_row  (in_data),
    .rd_en   (rd_en),
    .rd_pos  (rd_pos_d),
    .rd_ch   (rd_ch_d),
    .rd_data (out_data)
  );

  assign out_idx    = idx_q;
  assign out_last   = out_valid && (idx_q == IDX_LAST);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fc_input_flattener.sv
// Directed bench for fc_input_flattener: frames of known patterns are loaded
// and the channel-major output stream is checked scalar by scalar.
module tb_fc_input_flattener;

  localparam int DW  = 12;
  localparam int NCH = 16;
  localparam int MS  = 25;
  localparam int FCI = 400;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [NCH*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [8:0]      out_idx;
  logic            out_last;
  logic            frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fc_input_flattener dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  // Activation value of channel c at position p for each frame pattern.
  function automatic logic [DW-1:0] gen(input int kind, input int p, input int c);
    int v;
    case (kind)
      0:       v = c*32 + p;
      1:       v = -2048 + c*64 + p;
      2:       v = -1 - c*32 - p;
      3:       v = 100 + c*7 + p*3;
      default: v = 32'h5A5 ^ (c*p + 3);
    endcase
    return DW'(v);
  endfunction

  function automatic logic [NCH*DW-1:0] beat_word(input int kind, input int p);
    logic [NCH*DW-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*DW +: DW] = gen(kind, p, c);
    return w;
  endfunction

  // Sends nbeats beats of a pattern; optional idle gaps before some beats.
  // A full frame ends with the one-cycle latency check on the first scalar.
  task automatic fill_frame(input int kind, input bit gaps, input int nbeats);
    for (int p = 0; p < nbeats; p++) begin
      if (gaps && (p % 3 == 1)) begin
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = beat_word(kind, p);
      total++;
      if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL fill_handshake kind=%0d p=%0d got in_ready/out_valid=%b%b need 10",
                 kind, p, in_ready, out_valid);
      if ({in_ready, out_valid} !== 2'b10) bad++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (nbeats == MS) begin
      total++;
      if ({out_valid, out_idx, in_ready} !== {1'b1, 9'd0, 1'b0}) begin
        bad++;
        $display("FAIL latency kind=%0d got valid=%b idx=%0d in_ready=%b need 1/0/0",
                 kind, out_valid, out_idx, in_ready);
      end
    end
  endtask

  // Drains a loaded frame and checks every scalar against the channel-major
  // mapping. mode 1 randomises out_ready; pre_stall holds it low first.
  // hold keeps in_valid high with the next frame's beat 0 on in_data.
  // rst_at >= 0 asserts reset when that index is presented.
  task automatic drain_check(input int kind, input int mode, input bit hold,
                             input int next_kind, input int rst_at, input int pre_stall);
    int k = 0;
    int cyc = 0;
    int stall = pre_stall;
    logic [DW-1:0] exp_d;
    logic [23:0] got, need;
    while (k < FCI && cyc < 5000) begin
      if (hold) begin
        in_valid = 1'b1;
        in_data  = beat_word(next_kind, 0);
      end else begin
        in_valid = 1'b0;
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else if (mode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      exp_d = gen(kind, k % MS, k / MS);
      got  = {out_valid, out_idx, out_data, out_last, frame_done};
      need = {1'b1, 9'(k), exp_d, (k == FCI-1), 1'b0};
      total++;
      if (got !== need) begin
        bad++;
        $display("FAIL drain_beat kind=%0d k=%0d got v=%b idx=%0d d=%h last=%b fd=%b need idx=%0d d=%h last=%b",
                 kind, k, out_valid, out_idx, out_data, out_last, frame_done, k, exp_d, (k == FCI-1));
      end
      if (hold) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL drain_in_ready k=%0d got %b need 0", k, in_ready);
        end
      end
      if (rst_at >= 0 && k == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_idx, out_data, out_last, frame_done, in_ready} !==
            {1'b0, 9'd0, 12'd0, 1'b0, 1'b0, 1'b1}) begin
          bad++;
          $display("FAIL reset_mid_drain got v=%b idx=%0d d=%h last=%b fd=%b rdy=%b need 0/0/0/0/0/1",
                   out_valid, out_idx, out_data, out_last, frame_done, in_ready);
        end
        rst_n = 1'b1;
        return;
      end
      if (out_ready && out_valid === 1'b1) k++;
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (k < FCI) begin
      bad++;
      $display("FAIL drain_timeout kind=%0d got k=%0d need %0d", kind, k, FCI);
    end
    total++;
    if ({frame_done, out_valid, in_ready} !== 3'b101) begin
      bad++;
      $display("FAIL drain_exit kind=%0d got fd/v/rdy=%b%b%b need 101",
               kind, frame_done, out_valid, in_ready);
    end
    if (!hold) begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({frame_done, out_valid, in_ready} !== 3'b001) begin
        bad++;
        $display("FAIL frame_done_pulse got fd/v/rdy=%b%b%b need 001",
                 frame_done, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, out_idx, out_data, out_last, frame_done} !==
        {1'b1, 1'b0, 9'd0, 12'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b v=%b idx=%0d d=%h last=%b fd=%b need 1/0/0/0/0/0",
               in_ready, out_valid, out_idx, out_data, out_last, frame_done);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_frame();
    fill_frame(0, 1'b0, MS);
    drain_check(0, 0, 1'b0, 0, -1, 0);
  endtask

  task automatic test_backpressure();
    fill_frame(0, 1'b0, MS);
    drain_check(0, 1, 1'b0, 0, -1, 40);
  endtask

  task automatic test_input_gaps();
    fill_frame(2, 1'b1, MS);
    drain_check(2, 0, 1'b1, 3, -1, 0);
    fill_frame(3, 1'b0, MS);
    drain_check(3, 1, 1'b0, 0, -1, 0);
  endtask

  task automatic test_reset_mid_drain();
    fill_frame(1, 1'b0, MS);
    drain_check(1, 0, 1'b0, 0, 137, 0);
    fill_frame(3, 1'b0, MS);
    drain_check(3, 0, 1'b0, 0, -1, 0);
  endtask

  task automatic test_reset_mid_fill();
    fill_frame(4, 1'b0, 10);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_mid_fill got rdy/v=%b%b need 10", in_ready, out_valid);
    end
    rst_n = 1'b1;
    fill_frame(0, 1'b0, MS);
    drain_check(0, 0, 1'b0, 0, -1, 0);
  endtask

  task automatic test_back_to_back();
    fill_frame(1, 1'b0, MS);
    drain_check(1, 0, 1'b0, 0, -1, 0);
    fill_frame(2, 1'b0, MS);
    drain_check(2, 1, 1'b0, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_input_gaps();
    test_reset_mid_drain();
    test_reset_mid_fill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
